// File: rtl/divisor_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Optional macro: DIV_SEG_EN enables the 7-segment quotient display.
package divisor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    // Active-low segments {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        SEG_ZERO     // 0
    };

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        return SEG_TABLE[v];
    endfunction

endpackage

// File: rtl/divisor_seq_param_div_step.sv
// One restoring-division step: shift in a dividend bit, then
// subtract the divisor if it fits, otherwise keep the shifted value.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // Trial subtraction in WIDTH+2 bits so the sign bit is explicit.
    // A set top bit of rem means the shifted value already exceeds
    // any divisor, so the subtraction always succeeds in that case.
    always_comb begin
        shifted  = {rem[WIDTH-1:0], bit_in};
        diff     = {1'b0, shifted} - {2'b00, divisor};
        q_bit    = rem[WIDTH] | ~diff[WIDTH+1];
        rem_next = q_bit ? diff[WIDTH:0] : shifted;
    end

endmodule

// File: rtl/divisor_seq_param.sv
// Parametrised sequential restoring divider, one quotient bit per clock.
// Optional macro: DIV_SEG_EN adds the hex 7-segment quotient output.
module divisor_seq_param
    import divisor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
`ifdef DIV_SEG_EN
    ,
    output logic [6:0]       seg
`endif
);

    localparam int IW = $clog2(WIDTH);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("divisor_seq_param: WIDTH out of range");
        end
    endgenerate

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem_w;
    logic [WIDTH-1:0] q_w;
    logic [IW-1:0]    idx;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_upd;
    logic             accept;
    logic             last;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem_w),
        .bit_in  (dvd[idx]),
        .divisor (dvs),
        .rem_next(rem_next),
        .q_bit   (q_bit)
    );

    // Handshake decode and working quotient with the current bit merged.
    always_comb begin
        accept     = start && (state == IDLE || state == DONE);
        last       = (idx == '0);
        q_upd      = q_w;
        q_upd[idx] = q_bit;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; a zero divisor skips RUN entirely.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand, working and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd         <= '0;
            dvs         <= '0;
            rem_w       <= '0;
            q_w         <= '0;
            idx         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dvd   <= dividend;
            dvs   <= divisor;
            rem_w <= '0;
            q_w   <= '0;
            idx   <= IW'(WIDTH - 1);
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            rem_w <= rem_next;
            q_w   <= q_upd;
            idx   <= idx - IW'(1);
            if (last) begin
                quotient    <= q_upd;
                remainder   <= rem_next[WIDTH-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

    // Status flags straight from the state.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

`ifdef DIV_SEG_EN
    // Hex glyph of the low quotient nibble.
    always_comb begin
        seg = hex_seg(4'(quotient));
    end
`endif

endmodule

// File: doc/divisor_seq_param.md
# divisor_seq_param

Parametrised sequential restoring divider: unsigned WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock, MSB first. Next-generation replacement for the fixed 4-bit divider in the calculator datapath. Adds a start/busy/done handshake, a divide-by-zero flag, and result holding between operations. The optional 7-segment output drives the board display.

## Interface
- WIDTH, 4: operand, quotient and remainder width; legal range 2..16.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- dividend  in  WIDTH  unsigned dividend; sampled on the accepting edge.
- divisor  in  WIDTH  unsigned divisor; sampled on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE; results valid.
- quotient  out  WIDTH  registered quotient.
- remainder  out  WIDTH  registered remainder.
- div_by_zero  out  1  set when the latched divisor was 0; valid with done.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}, quotient[3:0] in hex; present only with DIV_SEG_EN.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE, start=1: latch dividend and divisor, clear the partial remainder (WIDTH+1 bits internally), set bit index = WIDTH-1.
  - Divisor ≠ 0: go to RUN.
  - Divisor = 0: go straight to DONE with quotient = all ones, remainder = latched dividend, div_by_zero=1.
- RUN, each edge:
  - r' = {r[WIDTH-1:0], dvd[index]}.
  - Compute d = r' − {1'b0, divisor} in WIDTH+2 bits.
  - If d ≥ 0, set q[index]=1 and r ← d; otherwise set q[index]=0 and r ← r' (restore).
  - Decrement index. On the edge that processes index 0, go to DONE and load quotient/remainder from the working registers.
- DONE: results are held. start=1 re-accepts as in IDLE (back-to-back operation); otherwise stay in DONE.
- start in RUN is ignored. Operand inputs may change freely outside the accepting edge.
- quotient, remainder and div_by_zero change only on entry to DONE or on reset. They hold the previous result during RUN.
- Reset at any time, including mid-RUN: state IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0; working registers = 0. The in-flight operation is discarded.
- Final remainder is always < divisor and fits in WIDTH bits. The internal extra bit is dropped on output.

## Timing
- The accepting edge is edge 0.
  - Nonzero divisor: busy=1 after edges 0..WIDTH-1; DONE entered at edge WIDTH; done=1, busy=0, results valid after edge WIDTH. Latency is WIDTH+1 edges.
  - Zero divisor: done=1 after edge 0. Latency is 1 edge; busy never asserts.
- Throughput with start held high: one result every WIDTH+1 cycles.
- busy and done are never high together. done falls on the edge that accepts a new start.
- seg is a combinational function of the registered quotient, so it has no extra latency.

## Configuration
- DIV_SEG_EN defined: the seg port and hex decoder are present.
  - Reset value is the "0" pattern, 7'b1000000.
  - Values A–F use standard hex glyphs.
- DIV_SEG_EN undefined: the seg port and decoder are absent. All other behaviour is identical.

## Structure
- Shared package divisor_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - SEG_ZERO and the 16-entry hex segment constant table;
  - WIDTH_MIN / WIDTH_MAX for elaboration checks.
- One sub-module, div_step: combinational shift-and-conditional-subtract. Inputs are partial remainder, next dividend bit and divisor; outputs are the next remainder and the quotient bit.
- The top contains the FSM, index counter, operand/working/result registers and the optional decoder.

## Test plan
- WIDTH=4, 13/4 -> Q=3, R=1, div_by_zero=0, done after 5 edges, busy for 4 cycles.
- WIDTH=4, 7/0 -> Q=15, R=7, div_by_zero=1, done after 1 edge, busy never high.
- WIDTH=4, 9/4 then start held in DONE with 15/15 -> first Q=2,R=1, then Q=1,R=0, each 5 edges apart. Under DIV_SEG_EN, seg shows 2 then 1.
- WIDTH=4, 14/3 with start pulsed again mid-RUN using 1/1 -> second start ignored; result Q=4, R=2.
- WIDTH=8, 255/16 -> Q=15, R=15 after 9 edges. Then rst_n low mid-RUN of 200/7 -> all outputs 0 immediately, state IDLE, no done.
- Random sweep, WIDTH=4 and 8, all operand pairs or 10k random -> Q, R match the reference model, R < divisor, and the latency rule holds.
